// File: rtl/ahb_matrix_pkg.sv
// Shared types and constants for the AHB bus-matrix output stage.
package ahb_matrix_pkg;

    // Encoded port number width; the matrix never has more than four input ports.
    localparam int unsigned PW = 2;

    typedef logic [PW-1:0] port_t;

    // AHB HTRANS encodings.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester after the pointer wins.
module ahb_rr_pick
    import ahb_matrix_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 3
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  port_t                i_ptr,
    output port_t                o_port,
    output logic                 o_none
);

    // Two constant-index passes stand in for a modulo scan: ports above the
    // pointer first, then wrap around to ports at or below it.
    always_comb begin
        o_port = '0;
        o_none = 1'b1;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (o_none && i_req[p] && (port_t'(p) > i_ptr)) begin
                o_port = port_t'(p);
                o_none = 1'b0;
            end
        end
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (o_none && i_req[p] && (port_t'(p) <= i_ptr)) begin
                o_port = port_t'(p);
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb_matrix_output_arbiter.sv
// Output-stage arbiter: round-robin grant of one slave port among the input
// ports, holding the grant through bursts and locked sequences.
module ahb_matrix_output_arbiter #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned PW        = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_PORTS-1:0]   sel_op,
    input  logic [2*NUM_PORTS-1:0] trans_op,
    input  logic [NUM_PORTS-1:0]   mastlock_op,
    input  logic                   HREADYM,
    output logic [PW-1:0]          addr_in_port,
    output logic                   no_port,
    output logic [NUM_PORTS-1:0]   active_op,
    output logic [PW-1:0]          data_in_port,
    output logic                   data_no_port
);

    import ahb_matrix_pkg::*;

    port_t                r_last;
    port_t                r_addr_port;
    logic                 r_addr_none;
    port_t                r_data_port;
    logic                 r_data_none;

    logic [NUM_PORTS-1:0] w_req;
    logic                 w_own_sel;
    logic [1:0]           w_own_trans;
    logic                 w_own_lock;
    logic                 w_hold;
    port_t                w_pick_port;
    logic                 w_pick_none;
    port_t                w_addr_port;
    logic                 w_no_port;

    // Per-port request: selected and not IDLE.
    always_comb begin
        w_req = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_req[i] = sel_op[i] & (trans_op[2*i +: 2] != IDLE);
        end
    end

    // Pick out the registered owner's select, HTRANS and lock to decide hold.
    always_comb begin
        w_own_sel   = 1'b0;
        w_own_trans = IDLE;
        w_own_lock  = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (r_addr_port == port_t'(i)) begin
                w_own_sel   = sel_op[i];
                w_own_trans = trans_op[2*i +: 2];
                w_own_lock  = mastlock_op[i];
            end
        end
        w_hold = ~r_addr_none & w_own_sel &
                 ((w_own_trans == BUSY) | (w_own_trans == SEQ) | w_own_lock);
    end

    ahb_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .i_req  (w_req),
        .i_ptr  (r_last),
        .o_port (w_pick_port),
        .o_none (w_pick_none)
    );

    // Address owner: frozen while stalled, held on burst/lock, else round-robin.
    // With no requester the port number parks at the previous owner.
    always_comb begin
        w_addr_port = r_addr_port;
        w_no_port   = r_addr_none;
        if (HREADYM && !w_hold) begin
            w_no_port = w_pick_none;
            if (!w_pick_none) begin
                w_addr_port = w_pick_port;
            end
        end else if (HREADYM) begin
            w_no_port = 1'b0;
        end
    end

    // One-hot presentation of the granted port's address phase.
    always_comb begin
        active_op = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            active_op[i] = ~w_no_port & (w_addr_port == port_t'(i)) & sel_op[i];
        end
    end

    // Owner, data-phase and round-robin pointer registers advance on HREADYM.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_last      <= port_t'(NUM_PORTS - 1);
            r_addr_port <= '0;
            r_addr_none <= 1'b1;
            r_data_port <= '0;
            r_data_none <= 1'b1;
        end else if (HREADYM) begin
            r_addr_port <= w_addr_port;
            r_addr_none <= w_no_port;
            r_data_port <= w_addr_port;
            r_data_none <= w_no_port;
            if (!w_no_port && !w_hold) begin
                r_last <= w_addr_port;
            end
        end
    end

    assign addr_in_port = w_addr_port;
    assign no_port      = w_no_port;
    assign data_in_port = r_data_port;
    assign data_no_port = r_data_none;

endmodule

// File: tb/tb_ahb_matrix_output_arbiter.sv
// Scoreboard bench for ahb_matrix_output_arbiter with a behavioural model.
module tb_ahb_matrix_output_arbiter;

    localparam int N = 3;

    logic           HCLK = 1'b0;
    logic           HRESET;
    logic [N-1:0]   sel_op;
    logic [2*N-1:0] trans_op;
    logic [N-1:0]   mastlock_op;
    logic           HREADYM;
    logic [1:0]     addr_in_port;
    logic           no_port;
    logic [N-1:0]   active_op;
    logic [1:0]     data_in_port;
    logic           data_no_port;

    ahb_matrix_output_arbiter #(
        .NUM_PORTS (N),
        .PW        (2)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .sel_op       (sel_op),
        .trans_op     (trans_op),
        .mastlock_op  (mastlock_op),
        .HREADYM      (HREADYM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .active_op    (active_op),
        .data_in_port (data_in_port),
        .data_no_port (data_no_port)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int addr;
        int none;
        int act;
        int dport;
        int dnone;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Model state: owner (-1 = nobody), parked port number, rr pointer, data phase.
    int m_own, m_park, m_last, m_dport, m_dnone;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_own   = -1;
        m_park  = 0;
        m_last  = N - 1;
        m_dport = 0;
        m_dnone = 1;
    endtask

    function automatic bit reqs(input int p);
        return sel_op[p] && (trans_op[2*p +: 2] != 2'b00);
    endfunction

    // Evaluate the arbitration rules for the current inputs, queue the
    // expected outputs, then advance the model as the clock edge would.
    task automatic model_step();
        exp_t e;
        int   g;
        bit   hold;
        int   tr;
        hold = 0;
        if (m_own >= 0) begin
            tr   = int'(trans_op[2*m_own +: 2]);
            hold = sel_op[m_own] && (tr == 1 || tr == 3 || mastlock_op[m_own]);
        end
        g = -1;
        if (!HREADYM || hold) begin
            g = m_own;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (m_last + k) % N;
                if (g < 0 && reqs(p)) g = p;
            end
        end
        e.addr  = (g >= 0) ? g : m_park;
        e.none  = (g < 0) ? 1 : 0;
        e.act   = (g >= 0 && sel_op[g]) ? (1 << g) : 0;
        e.dport = m_dport;
        e.dnone = m_dnone;
        q.push_back(e);
        if (HREADYM) begin
            if (g >= 0) begin
                if (!hold) m_last = g;
                m_park = g;
            end
            m_own   = g;
            m_dport = e.addr;
            m_dnone = e.none;
        end
    endtask

    task automatic step(input logic [N-1:0] s, input logic [2*N-1:0] t,
                        input logic [N-1:0] l, input logic r);
        @(posedge HCLK);
        #1;
        sel_op      = s;
        trans_op    = t;
        mastlock_op = l;
        HREADYM     = r;
        model_step();
    endtask

    // Asynchronous reset between clock edges, checked before any edge arrives.
    task automatic mid_reset();
        @(negedge HCLK);
        #1;
        sel_op      = '0;
        trans_op    = '0;
        mastlock_op = '0;
        HRESET      = 1'b1;
        #1;
        chk("reset_data_no_port", int'(data_no_port), 1);
        chk("reset_data_in_port", int'(data_in_port), 0);
        chk("reset_no_port", int'(no_port), 1);
        chk("reset_addr_in_port", int'(addr_in_port), 0);
        chk("reset_active_op", int'(active_op), 0);
        model_reset();
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    // Monitor: compare every cycle's outputs against the oldest expectation.
    always @(negedge HCLK) begin
        if (!HRESET && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("addr_in_port", int'(addr_in_port), e.addr);
            chk("no_port", int'(no_port), e.none);
            chk("active_op", int'(active_op), e.act);
            chk("data_in_port", int'(data_in_port), e.dport);
            chk("data_no_port", int'(data_no_port), e.dnone);
        end
    end

    initial begin
        HRESET      = 1'b1;
        sel_op      = '0;
        trans_op    = '0;
        mastlock_op = '0;
        HREADYM     = 1'b1;
        model_reset();
        #2;
        chk("por_data_no_port", int'(data_no_port), 1);
        chk("por_no_port", int'(no_port), 1);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Idle after reset.
        step(3'b000, 6'b000000, 3'b000, 1'b1);
        step(3'b000, 6'b000000, 3'b000, 1'b1);

        // Single request from port 1, then idle.
        step(3'b010, 6'b001000, 3'b000, 1'b1);
        step(3'b000, 6'b000000, 3'b000, 1'b1);

        // Fairness: all three NONSEQ every cycle.
        repeat (6) step(3'b111, 6'b101010, 3'b000, 1'b1);
        step(3'b000, 6'b000000, 3'b000, 1'b1);

        // Burst hold: port 2 INCR4 while port 0 keeps requesting.
        step(3'b101, 6'b100010, 3'b000, 1'b1);
        step(3'b101, 6'b110010, 3'b000, 1'b1);
        step(3'b101, 6'b110010, 3'b000, 1'b1);
        step(3'b101, 6'b110010, 3'b000, 1'b1);
        step(3'b001, 6'b000010, 3'b000, 1'b1);
        step(3'b000, 6'b000000, 3'b000, 1'b1);

        // Stall during port 1's burst while port 0 requests.
        step(3'b011, 6'b001010, 3'b000, 1'b1);
        step(3'b011, 6'b001110, 3'b000, 1'b0);
        step(3'b011, 6'b001110, 3'b000, 1'b0);
        step(3'b011, 6'b001110, 3'b000, 1'b0);
        step(3'b011, 6'b001110, 3'b000, 1'b1);
        step(3'b011, 6'b001010, 3'b000, 1'b1);
        step(3'b000, 6'b000000, 3'b000, 1'b1);

        // Locked port 0: IDLE then NONSEQ with lock keeps grant against port 1.
        step(3'b011, 6'b001010, 3'b001, 1'b1);
        step(3'b011, 6'b001000, 3'b001, 1'b1);
        step(3'b011, 6'b001010, 3'b001, 1'b1);
        mid_reset();
        step(3'b011, 6'b001010, 3'b000, 1'b1);
        step(3'b000, 6'b000000, 3'b000, 1'b1);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0]   s;
            logic [2*N-1:0] t;
            logic [N-1:0]   l;
            logic           r;
            s = N'($urandom);
            t = (2*N)'($urandom);
            l = '0;
            for (int i = 0; i < N; i++) l[i] = ($urandom_range(7) == 0);
            r = ($urandom_range(3) != 0);
            step(s, t, l, r);
            if ($urandom_range(99) == 0) mid_reset();
        end

        @(negedge HCLK);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
